image_diff_engine: RTL and testbench



---
 rtl/image_diff_engine.sv | 110 +++++++++++
 tb/tb_image_diff_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_diff_engine.sv
// Streams every pixel address through two image RAMs in lockstep, writes a thresholded
// absolute-difference image to a result port and counts the pixels above the threshold.
module image_diff_engine #(
    parameter int unsigned NUM_PIXELS = 81920,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] threshold_i,
    input  logic              binarize_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   diff_count_o,
    output logic [ADDR_W-1:0] img_address_o,
    output logic              img_chipselect_o,
    output logic              img_clken_o,
    input  logic [DATA_W-1:0] img1_readdata_i,
    input  logic [DATA_W-1:0] img2_readdata_i,
    output logic [ADDR_W-1:0] res_address_o,
    output logic              res_write_o,
    output logic [DATA_W-1:0] res_writedata_o,
    input  logic              res_waitrequest_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIXELS - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                wr_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic [DATA_W-1:0]   thr_q;
    logic                bin_q;

    logic                stall;
    logic [DATA_W-1:0]   diff;
    logic                pass;

    // A pending write held off by the result port freezes the entire pipe.
    assign stall = wr_q & res_waitrequest_i;

    always_comb begin
        diff = '0;
        if (img1_readdata_i >= img2_readdata_i) begin
            diff = img1_readdata_i - img2_readdata_i;
        end else begin
            diff = img2_readdata_i - img1_readdata_i;
        end
        pass    = wr_q && (diff > thr_q);
        count_d = pass ? count_q + (ADDR_W + 1)'(1) : count_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_q      <= 1'b0;
            count_q   <= '0;
            thr_q     <= '0;
            bin_q     <= 1'b0;
        end else if (!stall) begin
            // Not stalled, so any write presented this cycle is accepted.
            count_q <= count_d;
            unique case (state_q)
                StIdle, StDone: begin
                    wr_q    <= 1'b0;
                    state_q <= StIdle;
                    if (start_i) begin
                        state_q <= StRun;
                        addr_q  <= '0;
                        count_q <= '0;
                        thr_q   <= threshold_i;
                        bin_q   <= binarize_i;
                    end
                end
                StRun: begin
                    wr_q      <= 1'b1;
                    wr_addr_q <= addr_q;
                    if (addr_q == LastAddr) begin
                        state_q <= StDrain;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                StDrain: begin
                    wr_q    <= 1'b0;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o           = (state_q == StRun) || (state_q == StDrain);
    assign done_o           = (state_q == StDone);
    assign img_chipselect_o = busy_o;
    assign img_clken_o      = (state_q == StRun) && !stall;
    assign img_address_o    = addr_q;
    assign res_address_o    = wr_addr_q;
    assign res_write_o      = wr_q;
    assign res_writedata_o  = pass ? (bin_q ? '1 : diff) : '0;
    assign diff_count_o     = count_q;

endmodule

// File: tb/tb_image_diff_engine.sv
// Directed bench for image_diff_engine with 16-pixel images and behavioural RAM models.
module tb_image_diff_engine;

    localparam int NP = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    threshold = 8'd0;
    logic          binarize = 1'b0;
    logic          busy, done, img_cs, img_clken, res_write, res_wait;
    logic [AW:0]   diff_count;
    logic [AW-1:0] img_address, res_address;
    logic [7:0]    rd1, rd2, res_wdata;

    logic [7:0] mem1 [NP];
    logic [7:0] mem2 [NP];

    int total = 0;
    int bad = 0;

    int         wr_cnt [NP];
    logic [7:0] wr_data [NP];
    int nwr, ndone, clken_bad, stall_cycles, first_addr_k, first_wr_k;
    int busy_at_done, count_at_done, count_k1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (img_clken) begin
            rd1 <= mem1[img_address];
            rd2 <= mem2[img_address];
        end
    end

    image_diff_engine #(.NUM_PIXELS(NP), .ADDR_W(AW), .DATA_W(8)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .threshold_i       (threshold),
        .binarize_i        (binarize),
        .busy_o            (busy),
        .done_o            (done),
        .diff_count_o      (diff_count),
        .img_address_o     (img_address),
        .img_chipselect_o  (img_cs),
        .img_clken_o       (img_clken),
        .img1_readdata_i   (rd1),
        .img2_readdata_i   (rd2),
        .res_address_o     (res_address),
        .res_write_o       (res_write),
        .res_writedata_o   (res_wdata),
        .res_waitrequest_i (res_wait)
    );

    function automatic logic [7:0] exp_px(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] thr, input logic bin);
        int d;
        d = (int'(a) > int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
        if (d > int'(thr)) return bin ? 8'hFF : 8'(d);
        return 8'h00;
    endfunction

    // k counts negedges after the cycle in which start was high.
    task automatic do_run(input int max_k, input bit pre, input int stall_n, input int pulse_k,
                          input bit restart, output int done_k);
        int stall_left;
        for (int i = 0; i < NP; i++) begin
            wr_cnt[i] = 0;
            wr_data[i] = 8'h00;
        end
        nwr = 0; ndone = 0; clken_bad = 0; stall_cycles = 0;
        first_addr_k = -1; first_wr_k = -1; busy_at_done = -1; count_at_done = -1;
        count_k1 = -1; done_k = -1; stall_left = stall_n;
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            start = 1'b0;
            res_wait = 1'b0;
            if (k == pulse_k) begin
                start = 1'b1;
                threshold = 8'd0;
                binarize = ~binarize;
            end
            if (res_write && res_address == 4'd5 && stall_left > 0) begin
                res_wait = 1'b1;
                stall_left--;
                stall_cycles++;
            end
            #1;
            if (k == 1) count_k1 = int'(diff_count);
            if (res_wait && img_clken) clken_bad++;
            if (first_addr_k < 0 && img_clken && img_address == 4'd0) first_addr_k = k;
            if (first_wr_k < 0 && res_write) first_wr_k = k;
            if (res_write && !res_wait) begin
                wr_cnt[res_address]++;
                wr_data[res_address] = res_wdata;
                nwr++;
            end
            if (done) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    busy_at_done = int'(busy);
                    count_at_done = int'(diff_count);
                end
                if (restart) begin
                    start = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic load_ramp;
        for (int i = 0; i < NP; i++) begin
            mem1[i] = 8'(i * 10);
            mem2[i] = 8'd50;
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({busy, done, res_write, img_cs, img_clken} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b want 00000", {busy, done, res_write, img_cs, img_clken});
        end
        total++;
        if (img_address !== '0 || res_address !== '0 || res_wdata !== '0 || diff_count !== '0) begin
            bad++;
            $display("FAIL reset_values got a=%0d ra=%0d wd=%0d cnt=%0d want all 0",
                     img_address, res_address, res_wdata, diff_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    // Checks a completed unstalled-style run against the bench model.
    task automatic check_image(input string nm, input logic [7:0] thr, input logic bin,
                               input int exp_cnt, input int dk, input int exp_dk);
        total++;
        if (dk !== exp_dk) begin
            bad++;
            $display("FAIL %s done_cycle got %0d want %0d", nm, dk, exp_dk);
        end
        total++;
        if (nwr !== NP || ndone !== 1) begin
            bad++;
            $display("FAIL %s write_count got %0d/%0d want %0d/1", nm, nwr, ndone, NP);
        end
        for (int i = 0; i < NP; i++) begin
            total++;
            if (wr_cnt[i] !== 1 || wr_data[i] !== exp_px(mem1[i], mem2[i], thr, bin)) begin
                bad++;
                $display("FAIL %s pixel%0d got n=%0d d=%0d want n=1 d=%0d", nm, i, wr_cnt[i],
                         wr_data[i], exp_px(mem1[i], mem2[i], thr, bin));
            end
        end
        total++;
        if (count_at_done !== exp_cnt || busy_at_done !== 0) begin
            bad++;
            $display("FAIL %s count_at_done got %0d busy=%0d want %0d busy=0", nm, count_at_done,
                     busy_at_done, exp_cnt);
        end
    endtask

    task automatic test_basic(input logic bin);
        int dk;
        load_ramp();
        threshold = 8'd20;
        binarize = bin;
        do_run(24, 1'b0, 0, 0, 1'b0, dk);
        check_image(bin ? "binarize" : "basic", 8'd20, bin, 11, dk, 18);
        total++;
        if (first_addr_k !== 1 || first_wr_k !== 2) begin
            bad++;
            $display("FAIL latency got addr_k=%0d wr_k=%0d want 1 2", first_addr_k, first_wr_k);
        end
        total++;
        if (wr_data[0] !== (bin ? 8'hFF : 8'd50) || wr_data[3] !== 8'd0 || wr_data[7] !== 8'd0 ||
            wr_data[8] !== (bin ? 8'hFF : 8'd30)) begin
            bad++;
            $display("FAIL directed_pixels got %0d %0d %0d %0d", wr_data[0], wr_data[3],
                     wr_data[7], wr_data[8]);
        end
        total++;
        if (diff_count !== 5'd11 || done !== 1'b0) begin
            bad++;
            $display("FAIL count_held got %0d done=%b want 11 0", diff_count, done);
        end
    endtask

    task automatic test_threshold_edges;
        int dk;
        for (int i = 0; i < NP; i++) begin
            mem1[i] = 8'(i * 17 + 3);
            mem2[i] = 8'(i * 17 + 3);
        end
        threshold = 8'd0;
        binarize = 1'b0;
        do_run(24, 1'b0, 0, 0, 1'b0, dk);
        check_image("equal", 8'd0, 1'b0, 0, dk, 18);
        for (int i = 0; i < NP; i++) begin
            mem1[i] = 8'hFF;
            mem2[i] = 8'h00;
        end
        threshold = 8'd255;
        do_run(24, 1'b0, 0, 0, 1'b0, dk);
        check_image("thr255", 8'd255, 1'b0, 0, dk, 18);
    endtask

    task automatic test_stall;
        int dk;
        load_ramp();
        threshold = 8'd20;
        binarize = 1'b0;
        do_run(28, 1'b0, 3, 0, 1'b0, dk);
        check_image("stall", 8'd20, 1'b0, 11, dk, 21);
        total++;
        if (stall_cycles !== 3 || clken_bad !== 0) begin
            bad++;
            $display("FAIL stall_clken got stalls=%0d clken_hi=%0d want 3 0", stall_cycles,
                     clken_bad);
        end
    endtask

    task automatic test_reset_midrun;
        int dk;
        int stray;
        load_ramp();
        threshold = 8'd20;
        binarize = 1'b0;
        do_run(8, 1'b0, 0, 0, 1'b0, dk);
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || res_write !== 1'b0 || img_clken !== 1'b0 || diff_count !== '0) begin
            bad++;
            $display("FAIL abort got busy=%b wr=%b clken=%b cnt=%0d want 0 0 0 0", busy, res_write,
                     img_clken, diff_count);
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_write || busy) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL after_abort got active_cycles=%0d want 0", stray);
        end
        do_run(24, 1'b0, 0, 0, 1'b0, dk);
        check_image("rerun", 8'd20, 1'b0, 11, dk, 18);
    endtask

    task automatic test_busy_start;
        int dk;
        load_ramp();
        threshold = 8'd20;
        binarize = 1'b0;
        do_run(30, 1'b0, 0, 5, 1'b0, dk);
        check_image("busy_start", 8'd20, 1'b0, 11, dk, 18);
    endtask

    task automatic test_back_to_back;
        int dk;
        load_ramp();
        threshold = 8'd20;
        binarize = 1'b0;
        do_run(24, 1'b0, 0, 0, 1'b1, dk);
        check_image("b2b_first", 8'd20, 1'b0, 11, dk, 18);
        for (int i = 0; i < NP; i++) mem1[i] = mem2[i];
        threshold = 8'd0;
        do_run(24, 1'b1, 0, 0, 1'b0, dk);
        check_image("b2b_second", 8'd0, 1'b0, 0, dk, 18);
        total++;
        if (first_addr_k !== 1 || count_k1 !== 0) begin
            bad++;
            $display("FAIL b2b_restart got addr_k=%0d cnt=%0d want 1 0", first_addr_k, count_k1);
        end
    endtask

    initial begin
        res_wait = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_threshold_edges();
        test_stall();
        test_reset_midrun();
        test_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
